dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Frequency-sweep sequencer directly upstream of the DDS phase-accumulator core. Holds a small register file (start/stop/step frequency word, dwell, phase offset, mode) written over a simple write port. On `start` it drives the DDS `K` input through a linear sweep, one frequency word per dwell period. It also drives the DDS `P` input with a static phase offset. Outputs are registered and connect port-for-port to the DDS `K` and `P` inputs.

## Interface
- `DWELL_W`, 16, width of dwell counter; DWELL register uses bits [DWELL_W-1:0] of write data.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: register write strobe, one write per cycle.
- `cfg_addr` in 3: 0 START_K, 1 STOP_K, 2 STEP_K, 3 DWELL, 4 PHASE (bits [10:0]), 5 MODE (bit0 repeat, bit1 down); 6–7 ignored.
- `cfg_wdata` in 32: write data.
- `start` in 1: begin sweep (level sampled per cycle; acted on only in IDLE).
- `abort` in 1: stop sweep immediately.
- `K` out 32: frequency word to DDS.
- `P` out 11: phase word to DDS.
- `busy` out 1: high while sweeping.
- `k_upd` out 1: one-cycle pulse coincident with each new `K` value.
- `done` out 1: one-cycle pulse when a non-repeat sweep completes.

## Operation
- Reset: all config regs 0; `K`=0, `P`=0, `busy`=0, `k_upd`=0, `done`=0, dwell counter 0, state IDLE.
- Config writes are accepted at any time. They land in shadow registers. On a `start` accepted in IDLE, the shadow registers are copied into an active set. Writes during a sweep affect only the next sweep.
- States: IDLE, HOLD.
- IDLE + `start` (and no `abort`):
  - load active set.
  - `K`<=START_K, `P`<=PHASE, cnt<=DWELL, `k_upd`=1, `busy`=1.
  - go HOLD.
- HOLD, cnt≠0: cnt<=cnt−1, `K` unchanged.
- HOLD, cnt==0, `K`==STOP_K (end point):
  - repeat=1: `K`<=START_K, cnt<=DWELL, `k_upd`=1; stay HOLD.
  - repeat=0: go IDLE, `busy`<=0, `done`=1 pulse; `K` holds STOP_K.
- HOLD, cnt==0, `K`≠STOP_K: compute next word, `K`<=next, cnt<=DWELL, `k_upd`=1.
  - Up (MODE[1]=0): sum = {1'b0,K}+STEP (33-bit). If sum ≥ STOP_K or sum[32]=1, next=STOP_K; else next=sum[31:0].
  - Down (MODE[1]=1): if K < STOP_K + STEP, or the borrow from K−STEP is set, next=STOP_K; else next=K−STEP.
  - STEP_K==0: next=STOP_K (jump, no hang).
  - Direction inconsistent with START/STOP (e.g. up with START>STOP): the clamp rule makes the first step land on STOP_K.
- `abort` in any state:
  - go IDLE next cycle, `busy`<=0.
  - `K`/`P` hold current values.
  - no `done`, no `k_upd`.
- `abort` wins over `start` in the same cycle.
- `start` while HOLD is ignored.
- `P` changes only on an accepted start.

## Timing
- `start` sampled high at edge t:
  - new `K`/`P` visible after edge t, with `busy` and `k_upd`.
- Each frequency word is held exactly DWELL+1 cycles.
- Sweep of N distinct words (non-repeat): `busy` high for N·(DWELL+1) cycles.
  - `done` is high in the first cycle `busy` is low.
- Repeat: the START_K reload follows STOP_K's dwell with no gap cycle.
- Config write at edge t is visible to a `start` sampled at edge t+1 or later. A write and a start on the same edge use the old shadow value.
- Reset assertion mid-sweep: all outputs return to reset values asynchronously. Sweep does not resume on release.

## Test plan
- Up sweep: START=100, STOP=130, STEP=10, DWELL=2, MODE=0, pulse start.
  - Required: `K` = 100,110,120,130, each held 3 cycles.
  - `k_upd` ×4; `busy` 12 cycles; `done` one cycle after; `K` stays 130.
- Down clamp: START=1000, STOP=975, STEP=10, DWELL=0, MODE=2.
  - Required: `K` = 1000,990,980,975 on consecutive cycles; then `done`.
- Overflow/zero step:
  - START=0xFFFF_FFF0, STOP=0xFFFF_FFFF, STEP=0x20, up: `K` = FFFF_FFF0 → FFFF_FFFF.
  - STEP=0: `K` = START → STOP, then done.
- Repeat + abort: START=5, STOP=7, STEP=1, DWELL=1, MODE=1.
  - Required: 5,5,6,6,7,7,5,5,… with no `done`.
  - `abort` mid-word 6: `busy` low next cycle, `K` stays 6, no `done`.
- Shadow/ignore:
  - During a sweep, write START=500 and pulse start: current sweep unchanged.
  - Next start begins at 500 and `P` updates to the new PHASE.
  - `start`+`abort` same cycle in IDLE: nothing starts.
- Async reset mid-sweep: assert `rst_n`=0 between edges.
  - Required: `K`=0, `P`=0, `busy`=0 immediately.
  - After release: IDLE; config regs read back as zero, so a start with no writes gives `K`=0 and `done` after DWELL+1=1 cycle.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear frequency-sweep sequencer that feeds the K (frequency)
// and P (phase) inputs of a DDS phase-accumulator core. Configuration is written
// into shadow registers. These are copied to an active set when a sweep starts,
// so writes made during a sweep only affect the next one.
module dds_sweep_ctrl #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    input  logic               start,
    input  logic               abort,
    output logic [31:0]        K,
    output logic [10:0]        P,
    output logic               busy,
    output logic               k_upd,
    output logic               done
);

    typedef enum logic {IDLE, HOLD} state_t;

    // Shadow configuration (written any time)
    logic [31:0]        start_k_reg, stop_k_reg, step_k_reg;
    logic [DWELL_W-1:0] dwell_reg;
    logic [10:0]        phase_reg;
    logic [1:0]         mode_reg;

    // Active configuration (frozen for the duration of a sweep)
    logic [31:0]        act_start_reg, act_stop_reg, act_step_reg;
    logic [DWELL_W-1:0] act_dwell_reg;
    logic [1:0]         act_mode_reg;

    logic [31:0]        act_start_next, act_stop_next, act_step_next;
    logic [DWELL_W-1:0] act_dwell_next;
    logic [1:0]         act_mode_next;

    state_t             state_reg, state_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic [31:0]        k_next;
    logic [10:0]        p_next;
    logic               busy_next, k_upd_next, done_next;

    logic [32:0]        up_sum, dn_diff, dn_thresh;
    logic [31:0]        next_word;

    // Shadow register file write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_k_reg <= '0;
            stop_k_reg  <= '0;
            step_k_reg  <= '0;
            dwell_reg   <= '0;
            phase_reg   <= '0;
            mode_reg    <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    start_k_reg <= cfg_wdata;
                3'd1:    stop_k_reg  <= cfg_wdata;
                3'd2:    step_k_reg  <= cfg_wdata;
                3'd3:    dwell_reg   <= cfg_wdata[DWELL_W-1:0];
                3'd4:    phase_reg   <= cfg_wdata[10:0];
                3'd5:    mode_reg    <= cfg_wdata[1:0];
                default: ;
            endcase
        end
    end

    // Next frequency word: step toward STOP_K and clamp onto it on overshoot,
    // wrap-around, zero step or a direction that points away from STOP_K
    always_comb begin
        up_sum    = {1'b0, K} + {1'b0, act_step_reg};
        dn_diff   = {1'b0, K} - {1'b0, act_step_reg};
        dn_thresh = {1'b0, act_stop_reg} + {1'b0, act_step_reg};
        next_word = act_stop_reg;
        if (act_step_reg != 32'd0) begin
            if (!act_mode_reg[1]) begin
                if (!up_sum[32] && (up_sum[31:0] < act_stop_reg))
                    next_word = up_sum[31:0];
            end else begin
                if (!dn_diff[32] && ({1'b0, K} >= dn_thresh))
                    next_word = dn_diff[31:0];
            end
        end
    end

    // Sweep FSM next-state and registered-output logic
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        k_next         = K;
        p_next         = P;
        busy_next      = busy;
        k_upd_next     = 1'b0;
        done_next      = 1'b0;
        act_start_next = act_start_reg;
        act_stop_next  = act_stop_reg;
        act_step_next  = act_step_reg;
        act_dwell_next = act_dwell_reg;
        act_mode_next  = act_mode_reg;
        if (abort) begin
            state_next = IDLE;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        act_start_next = start_k_reg;
                        act_stop_next  = stop_k_reg;
                        act_step_next  = step_k_reg;
                        act_dwell_next = dwell_reg;
                        act_mode_next  = mode_reg;
                        k_next         = start_k_reg;
                        p_next         = phase_reg;
                        cnt_next       = dwell_reg;
                        k_upd_next     = 1'b1;
                        busy_next      = 1'b1;
                        state_next     = HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - 1'b1;
                    end else if (K == act_stop_reg) begin
                        if (act_mode_reg[0]) begin
                            k_next     = act_start_reg;
                            cnt_next   = act_dwell_reg;
                            k_upd_next = 1'b1;
                        end else begin
                            state_next = IDLE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end
                    end else begin
                        k_next     = next_word;
                        cnt_next   = act_dwell_reg;
                        k_upd_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, counter, active set and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            K             <= '0;
            P             <= '0;
            busy          <= 1'b0;
            k_upd         <= 1'b0;
            done          <= 1'b0;
            act_start_reg <= '0;
            act_stop_reg  <= '0;
            act_step_reg  <= '0;
            act_dwell_reg <= '0;
            act_mode_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            K             <= k_next;
            P             <= p_next;
            busy          <= busy_next;
            k_upd         <= k_upd_next;
            done          <= done_next;
            act_start_reg <= act_start_next;
            act_stop_reg  <= act_stop_next;
            act_step_reg  <= act_step_next;
            act_dwell_reg <= act_dwell_next;
            act_mode_reg  <= act_mode_next;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: stimulus pushes expected K/done events,
// a monitor pops and compares them whenever k_upd or done is presented.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        start;
    logic        abort;
    logic [31:0] K;
    logic [10:0] P;
    logic        busy;
    logic        k_upd;
    logic        done;

    typedef struct {
        bit          is_done;
        logic [31:0] k;
        logic [10:0] p;
        int          delta;
        int          blen;
        string       name;
    } ev_t;

    ev_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  cyc_cnt    = 0;
    int  last_ev    = 0;
    int  busy_len   = 0;
    bit  busy_prev  = 1'b0;

    dds_sweep_ctrl #(.DWELL_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .start    (start),
        .abort    (abort),
        .K        (K),
        .P        (P),
        .busy     (busy),
        .k_upd    (k_upd),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: measures busy run length and checks each presented event
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (busy && !busy_prev) busy_len = 1;
            else if (busy) busy_len++;
            busy_prev = busy;
            if (k_upd || done) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_event: k_upd=%0b done=%0b K=0x%08h, required no event",
                             k_upd, done, K);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_kind"}, {31'b0, done}, {31'b0, e.is_done});
                    if (!e.is_done) begin
                        chk({e.name, "_K"}, K, e.k);
                        chk({e.name, "_P"}, {21'b0, P}, {21'b0, e.p});
                    end else begin
                        chk({e.name, "_busy_len"}, 32'(busy_len), 32'(e.blen));
                    end
                    if (e.delta >= 0)
                        chk({e.name, "_hold"}, 32'(cyc_cnt - last_ev), 32'(e.delta));
                    $display("event %s: K=0x%08h P=0x%03h done=%0b", e.name, K, P, done);
                end
                last_ev = cyc_cnt;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic exp_k(input string n, input logic [31:0] k, input logic [10:0] p, input int d);
        exp_q.push_back('{1'b0, k, p, d, 0, n});
    endtask

    task automatic exp_done(input string n, input int d, input int bl);
        exp_q.push_back('{1'b1, 32'd0, 11'd0, d, bl, n});
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; abort = 1'b0;
        #2;
        chk("rst_K", K, 32'd0);
        chk("rst_P", {21'b0, P}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_kupd_done", {30'b0, k_upd, done}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Up sweep 100..130 step 10, dwell 2
        wr(3'd0, 32'd100); wr(3'd1, 32'd130); wr(3'd2, 32'd10);
        wr(3'd3, 32'd2);   wr(3'd5, 32'd0);   wr(3'd4, 32'h123);
        exp_k("up0", 32'd100, 11'h123, -1);
        exp_k("up1", 32'd110, 11'h123, 3);
        exp_k("up2", 32'd120, 11'h123, 3);
        exp_k("up3", 32'd130, 11'h123, 3);
        exp_done("up_done", 3, 12);
        pulse_start();
        cyc(20);
        chk("up_K_hold", K, 32'd130);
        chk("up_busy_low", {31'b0, busy}, 32'd0);

        // Down sweep with clamp onto STOP
        wr(3'd0, 32'd1000); wr(3'd1, 32'd975); wr(3'd2, 32'd10);
        wr(3'd3, 32'd0);    wr(3'd5, 32'd2);
        exp_k("dn0", 32'd1000, 11'h123, -1);
        exp_k("dn1", 32'd990, 11'h123, 1);
        exp_k("dn2", 32'd980, 11'h123, 1);
        exp_k("dn3", 32'd975, 11'h123, 1);
        exp_done("dn_done", 1, 4);
        pulse_start();
        cyc(10);

        // Up sweep whose step overflows 32 bits
        wr(3'd5, 32'd0); wr(3'd0, 32'hFFFF_FFF0); wr(3'd1, 32'hFFFF_FFFF); wr(3'd2, 32'h20);
        exp_k("ov0", 32'hFFFF_FFF0, 11'h123, -1);
        exp_k("ov1", 32'hFFFF_FFFF, 11'h123, 1);
        exp_done("ov_done", 1, 2);
        pulse_start();
        cyc(6);

        // Zero step jumps straight to STOP
        wr(3'd0, 32'd10); wr(3'd1, 32'd50); wr(3'd2, 32'd0);
        exp_k("z0", 32'd10, 11'h123, -1);
        exp_k("z1", 32'd50, 11'h123, 1);
        exp_done("z_done", 1, 2);
        pulse_start();
        cyc(6);

        // Repeat sweep, aborted in the middle of the second word 6
        wr(3'd0, 32'd5); wr(3'd1, 32'd7); wr(3'd2, 32'd1);
        wr(3'd3, 32'd1); wr(3'd5, 32'd1);
        exp_k("rp0", 32'd5, 11'h123, -1);
        exp_k("rp1", 32'd6, 11'h123, 2);
        exp_k("rp2", 32'd7, 11'h123, 2);
        exp_k("rp3", 32'd5, 11'h123, 2);
        exp_k("rp4", 32'd6, 11'h123, 2);
        pulse_start();
        cyc(8);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_K", K, 32'd6);
        chk("abort_no_pulse", {30'b0, k_upd, done}, 32'd0);
        cyc(6);
        chk("abort_K_later", K, 32'd6);

        // Shadow registers: writes and start during a sweep are not seen
        wr(3'd0, 32'd200); wr(3'd1, 32'd230); wr(3'd2, 32'd10);
        wr(3'd5, 32'd0);   wr(3'd4, 32'h055);
        exp_k("sh0", 32'd200, 11'h055, -1);
        exp_k("sh1", 32'd210, 11'h055, 2);
        exp_k("sh2", 32'd220, 11'h055, 2);
        exp_k("sh3", 32'd230, 11'h055, 2);
        exp_done("sh_done", 2, 8);
        pulse_start();
        wr(3'd0, 32'd500);
        wr(3'd4, 32'h077);
        pulse_start();
        cyc(12);
        exp_k("nx0", 32'd500, 11'h077, -1);
        exp_k("nx1", 32'd230, 11'h077, 2);
        exp_done("nx_done", 2, 4);
        pulse_start();
        cyc(8);

        // Write and start on the same edge: start uses the old START
        exp_k("se0", 32'd500, 11'h077, -1);
        exp_k("se1", 32'd230, 11'h077, 2);
        exp_done("se_done", 2, 4);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 32'd600; start = 1'b1;
        cyc(1);
        cfg_we = 1'b0; start = 1'b0;
        cyc(8);

        // Start and abort together in IDLE: nothing starts
        start = 1'b1; abort = 1'b1;
        cyc(1);
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", {31'b0, busy}, 32'd0);
        cyc(5);
        chk("sa_busy_later", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of a sweep
        wr(3'd0, 32'd1); wr(3'd1, 32'd3); wr(3'd2, 32'd1);
        wr(3'd3, 32'd5); wr(3'd4, 32'h010);
        exp_k("ar0", 32'd1, 11'h010, -1);
        pulse_start();
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_K", K, 32'd0);
        chk("ar_P", {21'b0, P}, 32'd0);
        chk("ar_busy", {31'b0, busy}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("ar_no_resume", {31'b0, busy}, 32'd0);
        exp_k("zr0", 32'd0, 11'h000, -1);
        exp_done("zr_done", 1, 1);
        pulse_start();
        cyc(5);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
